// File: rtl/bsg_mul_iterative_if.sv
// bsg_mul_iterative_if
//   Handshake bundle for the iterative multiplier.
//   Operand side (valid/ready): v_i, ready_o, x_i, y_i, x_signed_i, y_signed_i.
//   Result side (valid/yumi):   v_o, z_o, yumi_i.
//   The _i/_o suffixes are taken from the multiplier's point of view. The
//   multiplier connects to the slave modport, and its driver to the master
//   modport.
interface bsg_mul_iterative_if #(
  parameter int width_p = 32
);
  logic                   v_i;
  logic                   ready_o;
  logic [width_p-1:0]     x_i;
  logic [width_p-1:0]     y_i;
  logic                   x_signed_i;
  logic                   y_signed_i;
  logic                   v_o;
  logic [2*width_p-1:0]   z_o;
  logic                   yumi_i;

  modport slave (
    input  v_i, x_i, y_i, x_signed_i, y_signed_i, yumi_i,
    output ready_o, v_o, z_o
  );

  modport master (
    output v_i, x_i, y_i, x_signed_i, y_signed_i, yumi_i,
    input  ready_o, v_o, z_o
  );
endinterface

// File: rtl/bsg_mul_iterative.sv
// bsg_mul_iterative
//   Sequential sign/magnitude multiplier. It produces a 2*width_p-bit product
//   after width_p/bits_per_iter_p iteration cycles.
//   Ports:
//     clock_i    rising-edge clock
//     reset_n_i  asynchronous, active-low reset
//     bus        bsg_mul_iterative_if.slave
//                Operands arrive over valid/ready (v_i/ready_o).
//                The product leaves over valid/yumi (v_o/z_o/yumi_i).
//   Each operand carries its own signed flag. This covers the uu, su, us and
//   ss modes.
module bsg_mul_iterative #(
  parameter int width_p         = 32,
  parameter int bits_per_iter_p = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  bsg_mul_iterative_if.slave    bus
);

  localparam int iters_lp = width_p / bits_per_iter_p;
  localparam int cnt_w_lp = (iters_lp > 1) ? $clog2(iters_lp) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                         state_r;
  logic [width_p-1:0]                 x_mag_r;
  logic [2*width_p-1:0]               acc_r;
  logic [2*width_p-1:0]               z_r;
  logic                               neg_r;
  logic [cnt_w_lp-1:0]                cnt_r;

  logic                               x_neg;
  logic                               y_neg;
  logic [width_p-1:0]                 x_mag;
  logic [width_p-1:0]                 y_mag;
  logic [bits_per_iter_p-1:0]         digit;
  logic [width_p+bits_per_iter_p-1:0] partial;
  logic [width_p+bits_per_iter_p-1:0] sum;
  logic [2*width_p-1:0]               acc_next;

  // The datapath is a shift-add over a single double-width register.
  // The lower half starts out holding |y|, and its low bits are the current
  // multiplier digit. Each step adds |x|*digit into the upper half. The step
  // then shifts the whole register right by one digit. After the last
  // iteration, the register holds the full magnitude product.
  //
  // An operand's magnitude is its negation only when it is flagged signed
  // and its MSB is set. Negating -2^(w-1) wraps to 2^(w-1), which is the
  // correct unsigned magnitude in w bits.
  always_comb begin
    x_neg    = bus.x_signed_i & bus.x_i[width_p-1];
    y_neg    = bus.y_signed_i & bus.y_i[width_p-1];
    x_mag    = x_neg ? -bus.x_i : bus.x_i;
    y_mag    = y_neg ? -bus.y_i : bus.y_i;
    digit    = acc_r[bits_per_iter_p-1:0];
    partial  = {{bits_per_iter_p{1'b0}}, x_mag_r} * {{width_p{1'b0}}, digit};
    sum      = {{bits_per_iter_p{1'b0}}, acc_r[2*width_p-1:width_p]} + partial;
    acc_next = {sum, acc_r[width_p-1:bits_per_iter_p]};
  end

  // The control FSM runs IDLE -> CALC -> DONE.
  // The latency is fixed, so zero operands still take every iteration.
  // The result sign is applied once, on the transition into DONE.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      x_mag_r <= '0;
      acc_r   <= '0;
      z_r     <= '0;
      neg_r   <= 1'b0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.v_i) begin
            x_mag_r <= x_mag;
            acc_r   <= {{width_p{1'b0}}, y_mag};
            neg_r   <= x_neg ^ y_neg;
            cnt_r   <= cnt_w_lp'(iters_lp - 1);
            state_r <= CALC;
          end
        end
        CALC: begin
          acc_r <= acc_next;
          if (cnt_r == '0) begin
            z_r     <= neg_r ? -acc_next : acc_next;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r - cnt_w_lp'(1);
          end
        end
        DONE: begin
          if (bus.yumi_i) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.ready_o = (state_r == IDLE);
  assign bus.v_o     = (state_r == DONE);
  assign bus.z_o     = z_r;

endmodule

// File: tb/tb_bsg_mul_iterative.sv
// tb_bsg_mul_iterative
//   Directed bench for bsg_mul_iterative.
//   The main instance uses width_p=32 and bits_per_iter_p=2. It runs a
//   vector table, a back-pressure sequence and a mid-operation reset.
//   Six more instances sweep width_p over {8,16,32} and bits_per_iter_p
//   over {1,4}. Each of them checks its products against a 64-bit
//   sign-extended reference multiply.
module tb_bsg_mul_iterative;

  typedef struct {
    string       name;
    logic [31:0] x;
    logic [31:0] y;
    logic        xs;
    logic        ys;
    logic [63:0] z;
  } vec_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  bit   sweep_go;
  int   sweep_done;

  bsg_mul_iterative_if #(.width_p(32)) bus ();

  bsg_mul_iterative #(
    .width_p         (32),
    .bits_per_iter_p (2)
  ) u_dut (
    .clock_i   (clk),
    .reset_n_i (reset_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The check task is automatic because several processes call it
  // concurrently.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Wait (bounded) for ready_o, present one operand pair, and return
  // #1 after the accept edge.
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y,
                               input logic xs, input logic ys);
    int n;
    n = 0;
    while (!bus.ready_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.ready_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready timeout: got ready_o=0 expected 1");
    end
    bus.x_i        = x;
    bus.y_i        = y;
    bus.x_signed_i = xs;
    bus.y_signed_i = ys;
    bus.v_i        = 1'b1;
    @(posedge clk); #1;
    bus.v_i        = 1'b0;
  endtask

  // Count the clock edges after the accept edge until v_o rises.
  task automatic waitProduct(output int cyc);
    cyc = 0;
    while (!bus.v_o && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic releaseResult();
    bus.yumi_i = 1'b1;
    @(posedge clk); #1;
    bus.yumi_i = 1'b0;
  endtask

  // Parameter sweep instances. Each one waits for sweep_go, then runs
  // 12 operations over all four sign modes, including zero operands.
  for (genvar g = 0; g < 6; g++) begin : g_sweep
    localparam int sw = (g < 2) ? 8 : ((g < 4) ? 16 : 32);
    localparam int sb = (g % 2 == 0) ? 1 : 4;
    localparam int sn = sw / sb;

    bsg_mul_iterative_if #(.width_p(sw)) sbus ();

    bsg_mul_iterative #(
      .width_p         (sw),
      .bits_per_iter_p (sb)
    ) u_dut (
      .clock_i   (clk),
      .reset_n_i (reset_n),
      .bus       (sbus.slave)
    );

    initial begin
      logic [sw-1:0]   xv;
      logic [sw-1:0]   yv;
      logic [63:0]     xe;
      logic [63:0]     ye;
      logic [63:0]     pe;
      logic [2*sw-1:0] zexp;
      logic            xs;
      logic            ys;
      int              cyc;
      sbus.v_i        = 1'b0;
      sbus.x_i        = '0;
      sbus.y_i        = '0;
      sbus.x_signed_i = 1'b0;
      sbus.y_signed_i = 1'b0;
      sbus.yumi_i     = 1'b0;
      wait (sweep_go);
      @(posedge clk); #1;
      for (int i = 0; i < 12; i++) begin
        xs = i[0];
        ys = i[1];
        xv = sw'($urandom);
        yv = sw'($urandom);
        if (i == 8)  xv = '0;
        if (i == 9)  yv = '0;
        if (i == 10) begin xv = '0; yv = '0; end
        if (i == 11) begin xv = '0; yv = '1; end
        xe   = {{(64-sw){xs & xv[sw-1]}}, xv};
        ye   = {{(64-sw){ys & yv[sw-1]}}, yv};
        pe   = xe * ye;
        zexp = pe[2*sw-1:0];
        checkOutput($sformatf("sweep w%0d b%0d ready %0d", sw, sb, i),
                    64'(sbus.ready_o), 64'd1);
        sbus.x_i        = xv;
        sbus.y_i        = yv;
        sbus.x_signed_i = xs;
        sbus.y_signed_i = ys;
        sbus.v_i        = 1'b1;
        @(posedge clk); #1;
        sbus.v_i = 1'b0;
        cyc = 0;
        while (!sbus.v_o && cyc < 200) begin
          @(posedge clk); #1;
          cyc++;
        end
        checkOutput($sformatf("sweep w%0d b%0d z %0d", sw, sb, i),
                    64'(sbus.z_o), 64'(zexp));
        checkOutput($sformatf("sweep w%0d b%0d latency %0d", sw, sb, i),
                    64'(cyc), 64'(sn));
        sbus.yumi_i = 1'b1;
        @(posedge clk); #1;
        sbus.yumi_i = 1'b0;
      end
      sweep_done++;
    end
  end

  // The main sequence runs first: reset state, the vector table,
  // back-pressure, and a mid-operation reset. It then releases the
  // sweep instances and prints the summary line.
  initial begin
    vec_t vecs[11];
    int   cyc;
    int   n;
    bit   stale;
    logic [63:0] held;

    vecs[0]  = '{"umax",       32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE00000001};
    vecs[1]  = '{"ss min min", 32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000};
    vecs[2]  = '{"ss m1 m1",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h0000000000000001};
    vecs[3]  = '{"su mixed",   32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFE00000002};
    vecs[4]  = '{"us mixed",   32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1, 64'hFFFFFFFE00000002};
    vecs[5]  = '{"uu 3x5",     32'h00000003, 32'h00000005, 1'b0, 1'b0, 64'h000000000000000F};
    vecs[6]  = '{"ss m3x5",    32'hFFFFFFFD, 32'h00000005, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFF1};
    vecs[7]  = '{"su min umax",32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 64'h8000000080000000};
    vecs[8]  = '{"uu min min", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 64'h4000000000000000};
    vecs[9]  = '{"ss zero",    32'h00000000, 32'h80000000, 1'b1, 1'b1, 64'h0000000000000000};
    vecs[10] = '{"uu 2^16 sq", 32'h00010000, 32'h00010000, 1'b0, 1'b0, 64'h0000000100000000};

    checks         = 0;
    errors         = 0;
    sweep_go       = 1'b0;
    sweep_done     = 0;
    bus.v_i        = 1'b0;
    bus.x_i        = '0;
    bus.y_i        = '0;
    bus.x_signed_i = 1'b0;
    bus.y_signed_i = 1'b0;
    bus.yumi_i     = 1'b0;
    reset_n        = 1'b1;

    // Assert reset before any clock edge, so the reset-state checks can
    // only pass through the asynchronous path.
    #2 reset_n = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("reset ready_o", 64'(bus.ready_o), 64'd1);
    checkOutput("reset v_o",     64'(bus.v_o),     64'd0);
    checkOutput("reset z_o",     bus.z_o,          64'd0);
    #19 reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] vector table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].xs, vecs[i].ys);
      waitProduct(cyc);
      checkOutput({vecs[i].name, " z"},       bus.z_o,            vecs[i].z);
      checkOutput({vecs[i].name, " latency"}, 64'(cyc),           64'd16);
      checkOutput({vecs[i].name, " ready"},   64'(bus.ready_o),   64'd0);
      releaseResult();
    end

    $display("[TB] back-pressure");
    applyStimulus(32'd7, 32'd9, 1'b0, 1'b0);
    waitProduct(cyc);
    for (int i = 0; i < 5; i++) begin
      bus.v_i = ~bus.v_i;
      bus.x_i = $urandom;
      @(posedge clk); #1;
      checkOutput($sformatf("bp hold z %0d", i),     bus.z_o,          64'd63);
      checkOutput($sformatf("bp hold ready %0d", i), 64'(bus.ready_o), 64'd0);
    end
    bus.v_i = 1'b0;
    releaseResult();
    checkOutput("bp after yumi ready", 64'(bus.ready_o), 64'd1);
    checkOutput("bp after yumi v_o",   64'(bus.v_o),     64'd0);
    applyStimulus(32'h12345678, 32'h00000010, 1'b0, 1'b0);
    waitProduct(cyc);
    checkOutput("bp next z",       bus.z_o,  64'h0000000123456780);
    checkOutput("bp next latency", 64'(cyc), 64'd16);
    releaseResult();

    $display("[TB] reset mid-operation");
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    repeat (7) begin
      @(posedge clk); #1;
    end
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midreset v_o",   64'(bus.v_o),     64'd0);
    checkOutput("midreset ready", 64'(bus.ready_o), 64'd1);
    #2 reset_n = 1'b1;
    stale = 1'b0;
    for (n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.v_o) stale = 1'b1;
    end
    checkOutput("midreset no stale v_o", 64'(stale), 64'd0);
    applyStimulus(32'd3, 32'd5, 1'b0, 1'b0);
    waitProduct(cyc);
    checkOutput("midreset 3x5 z",       bus.z_o,  64'd15);
    checkOutput("midreset 3x5 latency", 64'(cyc), 64'd16);
    held = bus.z_o;
    releaseResult();
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("idle z_o holds", bus.z_o, held);

    $display("[TB] parameter sweep");
    sweep_go = 1'b1;
    n = 0;
    while (sweep_done < 6 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    checkOutput("sweep completion", 64'(sweep_done), 64'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
